// File: rtl/seg_display_sched_if.sv
// rtl/seg_display_sched_if.sv - request/grant bundle between display sources and the scheduler
interface seg_display_sched_if;
  logic [3:0]  req;
  logic [15:0] data0;
  logic [15:0] data1;
  logic [15:0] data2;
  logic [15:0] data3;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic [1:0]  src;
  logic        busy;

  modport master (output req, data0, data1, data2, data3,
                  input  grant, ack, src, busy);
  modport slave  (input  req, data0, data1, data2, data3,
                  output grant, ack, src, busy);
endinterface

// File: rtl/seg_display_sched.sv
// rtl/seg_display_sched.sv - round-robin / manual scheduler for the four-digit seven-segment display
module seg_display_sched #(
  parameter int DWELL    = 24000,
  parameter int DEBOUNCE = 5000,
  parameter int CW       = 32
) (
  input  logic                clk,
  input  logic                reset,
  seg_display_sched_if.slave  bus,
  input  logic                mode,
  input  logic                btn_next,
  output logic [3:0]          anw_0,
  output logic [3:0]          anw_1,
  output logic [3:0]          anw_2,
  output logic [3:0]          anw_3
);
  typedef enum logic [2:0] {IDLE, GRANT, HOLD, DONE, MANUAL} state_t;

  state_t          state, state_nx;
  logic [1:0]      ptr, win, sel, pick;
  logic [15:0]     shown, win_data, sel_data;
  logic [CW-1:0]   cnt, db_cnt;
  logic            sync0, sync1, db_level, db_prev;
  logic            any_req;

  function automatic logic [15:0] data_at(input logic [1:0] idx,
                                          input logic [15:0] d0, input logic [15:0] d1,
                                          input logic [15:0] d2, input logic [15:0] d3);
    case (idx)
      2'd0:    return d0;
      2'd1:    return d1;
      2'd2:    return d2;
      default: return d3;
    endcase
  endfunction

  // Search from ptr+4 down to ptr+1 so the nearest requester after ptr wins last.
  always_comb begin
    any_req = |bus.req;
    pick    = ptr;
    for (int k = 4; k >= 1; k--) begin
      if (bus.req[2'(ptr + 2'(k))]) pick = 2'(ptr + 2'(k));
    end
    win_data = data_at(win, bus.data0, bus.data1, bus.data2, bus.data3);
    sel_data = data_at(sel, bus.data0, bus.data1, bus.data2, bus.data3);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (mode) state_nx = MANUAL;
               else if (any_req) state_nx = GRANT;
      GRANT:   state_nx = HOLD;
      HOLD:    if (cnt == CW'(DWELL - 2)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      MANUAL:  if (!mode) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.grant <= '0;
      bus.ack   <= '0;
      bus.src   <= '0;
      bus.busy  <= 1'b0;
      ptr       <= 2'd3;
      win       <= '0;
      sel       <= '0;
      shown     <= '0;
      cnt       <= '0;
      db_cnt    <= '0;
      sync0     <= 1'b0;
      sync1     <= 1'b0;
      db_level  <= 1'b0;
      db_prev   <= 1'b0;
    end else begin
      sync0   <= btn_next;
      sync1   <= sync0;
      db_prev <= db_level;
      // The counter only runs while the synchronised level disagrees with the accepted one.
      if (sync1 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == CW'(DEBOUNCE - 1)) begin
        db_level <= sync1;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + CW'(1);
      end

      bus.ack <= '0;
      case (state)
        IDLE: if (!mode && any_req) begin
          bus.grant <= 4'b0001 << pick;
          bus.busy  <= 1'b1;
          win       <= pick;
          ptr       <= pick;
        end
        GRANT: begin
          shown   <= win_data;
          bus.src <= win;
          cnt     <= '0;
        end
        HOLD: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(DWELL - 2)) bus.ack <= bus.grant;
        end
        DONE: begin
          bus.grant <= '0;
          bus.busy  <= 1'b0;
        end
        MANUAL: begin
          shown   <= sel_data;
          bus.src <= sel;
          if (db_level && !db_prev) sel <= sel + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign anw_0 = shown[3:0];
  assign anw_1 = shown[7:4];
  assign anw_2 = shown[11:8];
  assign anw_3 = shown[15:12];
endmodule

// File: tb/tb_seg_display_sched.sv
// tb/tb_seg_display_sched.sv - self-checking bench for seg_display_sched
module tb_seg_display_sched;
  localparam int DWELL    = 4;
  localparam int DEBOUNCE = 3;

  logic        clk = 1'b0;
  logic        reset, mode, btn_next;
  logic [3:0]  anw_0, anw_1, anw_2, anw_3;
  logic [15:0] anw;
  logic [15:0] dat [4];
  logic [3:0]  pending;
  int          m_ptr, m_sel;
  int          checks = 0;
  int          errors = 0;

  seg_display_sched_if bus ();

  assign bus.req   = pending;
  assign bus.data0 = dat[0];
  assign bus.data1 = dat[1];
  assign bus.data2 = dat[2];
  assign bus.data3 = dat[3];
  assign anw = {anw_3, anw_2, anw_1, anw_0};

  seg_display_sched #(.DWELL(DWELL), .DEBOUNCE(DEBOUNCE), .CW(32)) dut (
    .clk(clk), .reset(reset), .bus(bus), .mode(mode), .btn_next(btn_next),
    .anw_0(anw_0), .anw_1(anw_1), .anw_2(anw_2), .anw_3(anw_3)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  function automatic int rr(input logic [3:0] r, input int p);
    for (int k = 1; k <= 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  // One full transaction from the IDLE cycle where the request is sampled.
  task automatic do_grant(input logic [3:0] mid_set, input logic [3:0] mid_clr, input logic mid_mode);
    int          w;
    logic [3:0]  oh, nb;
    logic [15:0] exp_data;
    w        = rr(pending, m_ptr);
    oh       = 4'(1 << w);
    exp_data = dat[w];
    step();
    chk("grant", 32'(bus.grant), 32'(oh));
    chk("busy", 32'(bus.busy), 32'd1);
    step();
    chk("shown", 32'(anw), 32'(exp_data));
    chk("src", 32'(bus.src), 32'(w));
    m_ptr = w;
    nb = mid_set & ~pending;
    for (int k = 0; k < 4; k++) if (nb[k]) dat[k] = 16'($urandom);
    pending = (pending | mid_set) & ~mid_clr;
    if (mid_mode) mode = 1'b1;
    repeat (DWELL - 2) step();
    chk("ack_early", 32'(bus.ack), 32'd0);
    step();
    chk("ack", 32'(bus.ack), 32'(oh));
    chk("grant_done", 32'(bus.grant), 32'(oh));
    pending[w] = 1'b0;
    step();
    chk("ack_end", 32'(bus.ack), 32'd0);
    chk("grant_end", 32'(bus.grant), 32'd0);
    chk("busy_end", 32'(bus.busy), 32'd0);
  endtask

  task automatic press();
    btn_next = 1'b1;
    repeat (DEBOUNCE + 6) step();
    btn_next = 1'b0;
    repeat (DEBOUNCE + 6) step();
    m_sel = (m_sel + 1) % 4;
    chk("man_src", 32'(bus.src), 32'(m_sel));
    chk("man_shown", 32'(anw), 32'(dat[m_sel]));
  endtask

  initial begin
    logic [3:0] nb;
    reset = 1'b1; mode = 1'b0; btn_next = 1'b0; pending = '0;
    for (int k = 0; k < 4; k++) dat[k] = 16'($urandom);
    m_ptr = 3; m_sel = 0;
    #12;
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_src", 32'(bus.src), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_anw", 32'(anw), 32'd0);
    step();
    reset = 1'b0;
    step();

    dat[0] = 16'h1A2B; pending = 4'b0001;
    do_grant('0, '0, 1'b0);

    for (int i = 0; i < 5; i++) begin
      pending = 4'hF;
      do_grant('0, '0, 1'b0);
    end

    pending = 4'b0100;
    do_grant(4'b0010, 4'b0100, 1'b0);
    do_grant('0, '0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      nb = 4'($urandom) & ~pending;
      for (int k = 0; k < 4; k++) if (nb[k]) dat[k] = 16'($urandom);
      pending = pending | nb;
      if (pending == 4'b0000) begin
        pending = 4'(1 << $urandom_range(3, 0));
        for (int k = 0; k < 4; k++) if (pending[k]) dat[k] = 16'($urandom);
      end
      do_grant(4'($urandom), 4'($urandom), 1'b0);
    end

    pending = 4'b1000;
    dat[3] = 16'hFACE;
    step();
    step();
    step();
    reset = 1'b1;
    #1;
    chk("rst_mid_grant", 32'(bus.grant), 32'd0);
    chk("rst_mid_ack", 32'(bus.ack), 32'd0);
    chk("rst_mid_anw", 32'(anw), 32'd0);
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    pending = '0;
    step();
    reset = 1'b0;
    m_ptr = 3; m_sel = 0;
    for (int i = 0; i < DWELL + 2; i++) begin
      step();
      chk("rst_no_ack", 32'(bus.ack), 32'd0);
    end

    dat[2] = 16'hBEEF;
    mode = 1'b1;
    step();
    step();
    chk("man_init_src", 32'(bus.src), 32'(m_sel));
    chk("man_init_shown", 32'(anw), 32'(dat[m_sel]));
    chk("man_grant", 32'(bus.grant), 32'd0);
    for (int i = 0; i < 3; i++) begin
      btn_next = 1'b1;
      step();
      btn_next = 1'b0;
      step();
    end
    repeat (DEBOUNCE + 6) step();
    chk("bounce_src", 32'(bus.src), 32'(m_sel));
    press();
    press();
    chk("beef", 32'(anw), 32'h0000BEEF);
    dat[2] = 16'h0123;
    step();
    chk("live_track", 32'(anw), 32'h00000123);
    press();
    for (int i = 0; i < 4; i++) press();

    mode = 1'b0;
    step();
    dat[0] = 16'h5555; dat[3] = 16'hC0DE;
    pending = 4'b0001;
    do_grant('0, '0, 1'b1);
    step();
    step();
    chk("sw_manual_shown", 32'(anw), 32'(dat[m_sel]));
    chk("sw_manual_src", 32'(bus.src), 32'(m_sel));
    chk("sw_manual_busy", 32'(bus.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
